// File: rtl/us_pkg.sv
// Shared types and default timing constants for the ultrasonic measurement path.
package us_pkg;

  // Measurement scheduler states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BURST  = 3'd1,
    BLANK  = 3'd2,
    LISTEN = 3'd3,
    EVAL   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  // Default cycle counts used by the sensor top level.
  localparam int unsigned DEF_BURST_CYC  = 40;
  localparam int unsigned DEF_BLANK_CYC  = 2000;
  localparam int unsigned DEF_LISTEN_CYC = 60000;
  localparam int unsigned DEF_PERIOD_CYC = 1000000;
  localparam int unsigned DEF_HIT_N      = 2;
  localparam int unsigned DEF_MISS_N     = 3;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/echo_detect_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a rising-edge pulse
// formed from the synchronized level and a one-cycle delayed copy.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Synchronizer chain plus delay stage for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_dly;

endmodule

// File: rtl/echo_detect_ctrl.sv
// Measurement scheduler: periodic burst, ring-down blanking, echo listen
// window with time-of-flight capture, hit/miss hysteresis on the CT LED and
// a free-running CT1 feedback pulse counter.
//
// Handshake note: there is no backpressure anywhere in this block. echo_valid
// and meas_abort are single-cycle strobes that the consumer must sample on the
// cycle they are high; echo_hit/echo_tof are only meaningful with echo_valid.
module echo_detect_ctrl
  import us_pkg::*;
#(
  parameter int unsigned BURST_CYC  = DEF_BURST_CYC,
  parameter int unsigned BLANK_CYC  = DEF_BLANK_CYC,
  parameter int unsigned LISTEN_CYC = DEF_LISTEN_CYC,
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned HIT_N      = DEF_HIT_N,
  parameter int unsigned MISS_N     = DEF_MISS_N,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic             chip_ready,
  input  logic             err_flag,
  input  logic             out3,
  input  logic             out4,
  input  logic             ct1,
  output logic             burst_en,
  output logic             ct,
  output logic             meas_busy,
  output logic             echo_valid,
  output logic             echo_hit,
  output logic [31:0]      echo_tof,
  output logic             meas_abort,
  output logic [CNT_W-1:0] ct1_count
);

  localparam int unsigned HCW = $clog2(HIT_N + 1);
  localparam int unsigned MCW = $clog2(MISS_N + 1);

  // Timer values at which each phase ends.
  localparam logic [31:0] L_BURST_LAST  = 32'(BURST_CYC - 1);
  localparam logic [31:0] L_BLANK_LAST  = 32'(BURST_CYC + BLANK_CYC - 1);
  localparam logic [31:0] L_LISTEN_LAST = 32'(BURST_CYC + BLANK_CYC + LISTEN_CYC - 1);
  localparam logic [31:0] L_PERIOD_LAST = 32'(PERIOD_CYC - 1);

  localparam logic [HCW-1:0] L_HIT_SAT  = HCW'(HIT_N);
  localparam logic [MCW-1:0] L_MISS_SAT = MCW'(MISS_N);

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_timer;
  logic [HCW-1:0]   r_hit_cnt;
  logic [MCW-1:0]   r_miss_cnt;
  logic [HCW-1:0]   w_hit_cnt_nx;
  logic [MCW-1:0]   w_miss_cnt_nx;
  logic             w_ct_nx;
  logic             w_lost;
  logic             w_abort;
  logic             w_eval_hit;
  logic             w_eval_miss;
  logic             w_echo;

  logic             r_burst_en;
  logic             r_ct;
  logic             r_meas_busy;
  logic             r_echo_valid;
  logic             r_echo_hit;
  logic [31:0]      r_echo_tof;
  logic             r_meas_abort;
  logic [CNT_W-1:0] r_ct1_count;

  logic w_out3_lvl, w_out3_rise;
  logic w_out4_lvl, w_out4_rise;
  logic w_ct1_lvl,  w_ct1_rise;
  logic w_unused_taps;

  sync_edge u_sync_out3 (.i_clk(gclk), .i_rst_n(rstn), .i_async(out3), .o_sync(w_out3_lvl), .o_rise(w_out3_rise));
  sync_edge u_sync_out4 (.i_clk(gclk), .i_rst_n(rstn), .i_async(out4), .o_sync(w_out4_lvl), .o_rise(w_out4_rise));
  sync_edge u_sync_ct1  (.i_clk(gclk), .i_rst_n(rstn), .i_async(ct1),  .o_sync(w_ct1_lvl),  .o_rise(w_ct1_rise));

  // Synchronizer taps this block has no use for.
  assign w_unused_taps = &{1'b0, w_out3_rise, w_out4_lvl, w_ct1_lvl};

  // Qualified echo: out4 rising while out3 reports a stable comparator.
  assign w_echo = w_out4_rise & w_out3_lvl;

  // Next state; priority is chip_ready loss, then error abort, then hit/timeout.
  always_comb begin
    w_next_state = r_state;
    w_lost       = 1'b0;
    w_abort      = 1'b0;
    w_eval_hit   = 1'b0;
    w_eval_miss  = 1'b0;
    if (r_state != IDLE && !chip_ready) begin
      w_next_state = IDLE;
      w_lost       = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (chip_ready) w_next_state = BURST;
        BURST: begin
          if (err_flag) begin
            w_next_state = WAIT;
            w_abort      = 1'b1;
          end else if (r_timer == L_BURST_LAST) begin
            w_next_state = BLANK;
          end
        end
        BLANK: begin
          if (err_flag) begin
            w_next_state = WAIT;
            w_abort      = 1'b1;
          end else if (r_timer == L_BLANK_LAST) begin
            w_next_state = LISTEN;
          end
        end
        LISTEN: begin
          if (err_flag) begin
            w_next_state = WAIT;
            w_abort      = 1'b1;
          end else if (w_echo) begin
            w_next_state = EVAL;
            w_eval_hit   = 1'b1;
          end else if (r_timer == L_LISTEN_LAST) begin
            w_next_state = EVAL;
            w_eval_miss  = 1'b1;
          end
        end
        EVAL: w_next_state = WAIT;
        WAIT: if (r_timer == L_PERIOD_LAST) w_next_state = chip_ready ? BURST : IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Streak counters and LED hysteresis, evaluated as the result is produced.
  always_comb begin
    w_hit_cnt_nx  = r_hit_cnt;
    w_miss_cnt_nx = r_miss_cnt;
    w_ct_nx       = r_ct;
    if (w_lost) begin
      w_hit_cnt_nx  = '0;
      w_miss_cnt_nx = '0;
      w_ct_nx       = 1'b0;
    end else if (w_eval_hit) begin
      w_hit_cnt_nx  = (r_hit_cnt == L_HIT_SAT) ? r_hit_cnt : r_hit_cnt + 1'b1;
      w_miss_cnt_nx = '0;
      if (w_hit_cnt_nx == L_HIT_SAT) w_ct_nx = 1'b1;
    end else if (w_eval_miss) begin
      w_miss_cnt_nx = (r_miss_cnt == L_MISS_SAT) ? r_miss_cnt : r_miss_cnt + 1'b1;
      w_hit_cnt_nx  = '0;
      if (w_miss_cnt_nx == L_MISS_SAT) w_ct_nx = 1'b0;
    end
  end

  // State, timer, streaks and registered outputs.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_burst_en   <= 1'b0;
      r_ct         <= 1'b0;
      r_meas_busy  <= 1'b0;
      r_echo_valid <= 1'b0;
      r_echo_hit   <= 1'b0;
      r_echo_tof   <= '0;
      r_meas_abort <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= (w_next_state == BURST && r_state != BURST) ? 32'd0 : r_timer + 32'd1;
      r_hit_cnt    <= w_hit_cnt_nx;
      r_miss_cnt   <= w_miss_cnt_nx;
      r_ct         <= w_ct_nx;
      r_burst_en   <= (w_next_state == BURST);
      r_meas_busy  <= (w_next_state != IDLE) && (w_next_state != WAIT);
      r_echo_valid <= w_eval_hit | w_eval_miss;
      r_meas_abort <= w_abort;
      if (w_eval_hit | w_eval_miss) begin
        r_echo_hit <= w_eval_hit;
        r_echo_tof <= w_eval_hit ? r_timer : 32'd0;
      end
    end
  end

  // CT1 feedback pulse counter, free running and wrapping.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) r_ct1_count <= '0;
    else if (w_ct1_rise) r_ct1_count <= r_ct1_count + 1'b1;
  end

  assign burst_en   = r_burst_en;
  assign ct         = r_ct;
  assign meas_busy  = r_meas_busy;
  assign echo_valid = r_echo_valid;
  assign echo_hit   = r_echo_hit;
  assign echo_tof   = r_echo_tof;
  assign meas_abort = r_meas_abort;
  assign ct1_count  = r_ct1_count;

endmodule

// File: tb/tb_echo_detect_ctrl.sv
// Bench for echo_detect_ctrl: per-period scenarios (echo, blanked echo,
// unqualified echo, no echo, error abort, chip_ready loss) with a
// measurement-level reference model.
module tb_echo_detect_ctrl;

  localparam int BURST_CYC  = 4;
  localparam int BLANK_CYC  = 8;
  localparam int LISTEN_CYC = 32;
  localparam int PERIOD_CYC = 64;
  localparam int HIT_N      = 2;
  localparam int MISS_N     = 3;
  localparam int CNT_W      = 16;

  localparam int LISTEN_FIRST = BURST_CYC + BLANK_CYC;
  localparam int LISTEN_LAST  = LISTEN_FIRST + LISTEN_CYC - 1;

  // Scenario kinds.
  localparam int K_ECHO  = 0;  // out4 pulse at p with out3 high
  localparam int K_NOQ   = 1;  // out4 pulse at p with out3 low
  localparam int K_NONE  = 2;  // no echo
  localparam int K_ERR   = 3;  // err_flag at p
  localparam int K_DROP  = 4;  // chip_ready loss at p

  logic             gclk;
  logic             rstn;
  logic             chip_ready;
  logic             err_flag;
  logic             out3;
  logic             out4;
  logic             ct1;
  logic             burst_en;
  logic             ct;
  logic             meas_busy;
  logic             echo_valid;
  logic             echo_hit;
  logic [31:0]      echo_tof;
  logic             meas_abort;
  logic [CNT_W-1:0] ct1_count;

  echo_detect_ctrl #(
    .BURST_CYC(BURST_CYC), .BLANK_CYC(BLANK_CYC), .LISTEN_CYC(LISTEN_CYC),
    .PERIOD_CYC(PERIOD_CYC), .HIT_N(HIT_N), .MISS_N(MISS_N), .CNT_W(CNT_W)
  ) dut (
    .gclk(gclk), .rstn(rstn), .chip_ready(chip_ready), .err_flag(err_flag),
    .out3(out3), .out4(out4), .ct1(ct1), .burst_en(burst_en), .ct(ct),
    .meas_busy(meas_busy), .echo_valid(echo_valid), .echo_hit(echo_hit),
    .echo_tof(echo_tof), .meas_abort(meas_abort), .ct1_count(ct1_count)
  );

  // ---------------- clock ----------------
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // ---------------- scoreboard / model ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [32:0] exp_q[$];     // {hit, tof} per completed measurement
  bit          hist[$];      // measurement outcomes since last LED clear
  bit          m_ct = 1'b0;
  int unsigned m_ct1 = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, act, exp);
    end
  endtask

  // LED rule: last HIT_N outcomes all hits sets it, last MISS_N all misses clears it.
  function automatic void model_outcome(input bit hit);
    int n;
    bit all_hit, all_miss;
    hist.push_back(hit);
    n = hist.size();
    if (n >= HIT_N) begin
      all_hit = 1'b1;
      for (int i = n - HIT_N; i < n; i++) if (!hist[i]) all_hit = 1'b0;
      if (all_hit) m_ct = 1'b1;
    end
    if (n >= MISS_N) begin
      all_miss = 1'b1;
      for (int i = n - MISS_N; i < n; i++) if (hist[i]) all_miss = 1'b0;
      if (all_miss) m_ct = 1'b0;
    end
  endfunction

  // Random CT1 activity, only early in the period so the count has settled by the end.
  task automatic drive_ct1(input int t);
    logic nv;
    if (t <= PERIOD_CYC - 9 && $urandom_range(0, 2) == 0) begin
      nv = ~ct1;
      if (nv) m_ct1 = (m_ct1 + 1) % (1 << CNT_W);
      ct1 = nv;
    end
  endtask

  // ---------------- driver ----------------
  // Entered at the negedge where the timer reads 0 (burst_en just rose).
  task automatic run_period(input int kind, input int p);
    bit          hit;
    bit          abort;
    int          vt;
    logic [31:0] tof;
    logic [32:0] e;
    bit          exp_valid;
    hit   = (kind == K_ECHO) && (p + 2 >= LISTEN_FIRST) && (p + 2 <= LISTEN_LAST);
    abort = (kind == K_ERR);
    vt    = hit ? p + 3 : LISTEN_LAST + 1;
    tof   = hit ? 32'(p + 2) : 32'd0;
    if (!abort && kind != K_DROP) exp_q.push_back({hit, tof});
    out3 = (kind != K_NOQ);
    for (int t = 0; t < PERIOD_CYC; t++) begin
      if (kind == K_DROP && t == p + 1) begin
        hist.delete();
        m_ct = 1'b0;
        check("drop_burst_en", 32'(burst_en), 32'd0);
        check("drop_ct", 32'(ct), 32'd0);
        check("drop_busy", 32'(meas_busy), 32'd0);
        check("drop_valid", 32'(echo_valid), 32'd0);
        check("drop_abort", 32'(meas_abort), 32'd0);
        repeat (3) begin
          @(negedge gclk);
          check("idle_burst_en", 32'(burst_en), 32'd0);
          check("idle_busy", 32'(meas_busy), 32'd0);
        end
        chip_ready = 1'b1;
        @(negedge gclk);
        check("restart_burst_en", 32'(burst_en), 32'd1);
        return;
      end
      check($sformatf("burst_en_t%0d", t), 32'(burst_en),
            32'((t < BURST_CYC) && !(abort && t > p)));
      check($sformatf("busy_t%0d", t), 32'(meas_busy), 32'(abort ? (t <= p) : (t <= vt)));
      exp_valid = !abort && kind != K_DROP && t == vt;
      check($sformatf("valid_t%0d", t), 32'(echo_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          model_outcome(e[32]);
          check("echo_hit", 32'(echo_hit), 32'(e[32]));
          check("echo_tof", echo_tof, e[31:0]);
        end
      end
      check($sformatf("abort_t%0d", t), 32'(meas_abort), 32'(abort && t == p + 1));
      check($sformatf("ct_t%0d", t), 32'(ct), 32'(m_ct));
      if (t == PERIOD_CYC - 1) check("ct1_count", 32'(ct1_count), m_ct1);
      out4     = (kind == K_ECHO || kind == K_NOQ) && t >= p && t < p + 4;
      err_flag = abort && t == p;
      if (kind == K_DROP && t == p) chip_ready = 1'b0;
      drive_ct1(t);
      @(negedge gclk);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int kind;
    int p;
    rstn = 1'b0; chip_ready = 1'b0; err_flag = 1'b0;
    out3 = 1'b0; out4 = 1'b0; ct1 = 1'b0;
    repeat (3) @(negedge gclk);
    check("rst_burst_en", 32'(burst_en), 32'd0);
    check("rst_ct", 32'(ct), 32'd0);
    check("rst_busy", 32'(meas_busy), 32'd0);
    check("rst_valid", 32'(echo_valid), 32'd0);
    check("rst_hit", 32'(echo_hit), 32'd0);
    check("rst_tof", echo_tof, 32'd0);
    check("rst_abort", 32'(meas_abort), 32'd0);
    check("rst_ct1_count", 32'(ct1_count), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge gclk);
    check("idle_no_ready", 32'(burst_en), 32'd0);
    chip_ready = 1'b1;
    @(negedge gclk);
    check("first_burst", 32'(burst_en), 32'd1);

    // Directed: echo timing, window edges, hysteresis, abort, chip_ready loss.
    run_period(K_ECHO, 20);   // tof 22
    run_period(K_ECHO, 10);   // first LISTEN cycle, LED sets
    run_period(K_ERR, 8);     // abort, LED holds
    run_period(K_ECHO, 9);    // detected in last BLANK cycle -> miss
    run_period(K_ECHO, 42);   // detected after window -> miss
    run_period(K_NOQ, 20);    // unqualified -> third miss, LED clears
    run_period(K_ECHO, 41);   // last LISTEN cycle
    run_period(K_ECHO, 30);   // LED sets
    run_period(K_DROP, 20);   // LED clears on loss
    run_period(K_NONE, 0);
    run_period(K_ERR, 0);
    run_period(K_ERR, 43);

    // Random periods.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        K_ECHO:  p = int'($urandom_range(0, 45));
        K_NOQ:   p = int'($urandom_range(10, 41));
        K_ERR:   p = int'($urandom_range(0, 43));
        K_DROP:  p = int'($urandom_range(12, 40));
        default: p = 0;
      endcase
      run_period(kind, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
